conv_frame_ctrl: RTL and testbench

Frame-level controller between the SPI byte interface and the convolution datapath. It parses a 3-byte header (command, width, height) from the received SPI byte stream, then forwards exactly width×height pixel bytes to the convolution core with frame, line and end markers. It buffers convolution results in a small FIFO that the SPI transmit side drains. It also detects aborted frames, bad headers and FIFO over/underflow.

---
 rtl/conv_ctrl_pkg.sv | 34 +++
 rtl/conv_frame_ctrl_result_fifo.sv | 63 ++++++
 rtl/conv_frame_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution frame controller.
// State encoding, error-flag bit positions and pixel bundle.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_W,
    HDR_H,
    PIXELS,
    DONE,
    ERROR
  } state_t;

  localparam int ERR_BAD_HDR = 0;
  localparam int ERR_ABORT   = 1;
  localparam int ERR_OVF     = 2;
  localparam int ERR_UDF     = 3;

  localparam logic [7:0] DEF_START_CMD = 8'hA5;
  localparam logic [7:0] DEF_FILL_BYTE = 8'h00;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       fs;
    logic       ls;
    logic       fe;
  } pix_t;

  function automatic logic in_frame(state_t s);
    return (s == HDR_W) || (s == HDR_H) || (s == PIXELS);
  endfunction

endpackage

// File: rtl/conv_frame_ctrl_result_fifo.sv
// Result FIFO between the conv core and the SPI transmit side.
// Pop on empty is ignored; push on full only succeeds with a pop.
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; data array needs no reset.
  always_ff @(posedge CLK) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping, flush empties the queue.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame controller: header parse, pixel forwarding with markers,
// result buffering for SPI readback and sticky error reporting.
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] START_CMD  = DEF_START_CMD,
  parameter logic [7:0] FILL_BYTE  = DEF_FILL_BYTE
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ssel_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       pix_valid,
  output logic [7:0] pix_data,
  output logic       frame_start,
  output logic       line_start,
  output logic       frame_end,
  output logic       frame_abort,
  input  logic       res_valid,
  input  logic [7:0] res_data,
  input  logic       tx_req,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic [3:0] err_flags
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t     state_q, state_d;
  logic [7:0] w_q, w_d;
  logic [7:0] h_q, h_d;
  logic [7:0] col_q, col_d;
  logic [7:0] row_q, row_d;
  pix_t       pix_q, pix_d;
  logic       abort_q, abort_d;
  logic       busy_q;
  logic [3:0] err_q, err_d;
  logic       bad_hdr;
  logic       start_acc;
  logic       last;

  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ovf_evt;
  logic          udf_evt;

  assign last = (col_q == w_q - 8'd1) && (row_q == h_q - 8'd1);

  // Next state, counters and the registered pixel bundle.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    col_d     = col_q;
    row_d     = row_q;
    pix_d     = '0;
    abort_d   = 1'b0;
    bad_hdr   = 1'b0;
    start_acc = 1'b0;
    if (!ssel_active) begin
      state_d = IDLE;
      abort_d = in_frame(state_q);
    end else if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (rx_byte == START_CMD) begin
            state_d   = HDR_W;
            start_acc = 1'b1;
          end
        end
        HDR_W: begin
          if (rx_byte == 8'd0) begin
            state_d = ERROR;
            bad_hdr = 1'b1;
          end else begin
            w_d     = rx_byte;
            state_d = HDR_H;
          end
        end
        HDR_H: begin
          if (rx_byte == 8'd0) begin
            state_d = ERROR;
            bad_hdr = 1'b1;
          end else begin
            h_d     = rx_byte;
            col_d   = 8'd0;
            row_d   = 8'd0;
            state_d = PIXELS;
          end
        end
        PIXELS: begin
          pix_d.valid = 1'b1;
          pix_d.data  = rx_byte;
          pix_d.fs    = (row_q == 8'd0) && (col_q == 8'd0);
          pix_d.ls    = (col_q == 8'd0);
          pix_d.fe    = last;
          if (col_q == w_q - 8'd1) begin
            col_d = 8'd0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
          if (last)
            state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  assign ovf_evt = res_valid && fifo_full && !tx_req;
  assign udf_evt = tx_req && fifo_empty;

  // Sticky flags; a new frame start clears them all.
  always_comb begin
    err_d = err_q;
    err_d[ERR_BAD_HDR] = err_q[ERR_BAD_HDR] | bad_hdr;
    err_d[ERR_ABORT]   = err_q[ERR_ABORT] | abort_d;
    err_d[ERR_OVF]     = err_q[ERR_OVF] | ovf_evt;
    err_d[ERR_UDF]     = err_q[ERR_UDF] | udf_evt;
    if (start_acc)
      err_d = '0;
  end

  // All control state and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pix_q   <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pix_q   <= pix_d;
      abort_q <= abort_d;
      busy_q  <= (state_d != IDLE);
      err_q   <= err_d;
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8),
    .CW    (CW)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .flush   (start_acc),
    .push    (res_valid),
    .pop     (tx_req),
    .din     (res_data),
    .head    (fifo_head),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_byte     = (fifo_cnt == '0) ? FILL_BYTE : fifo_head;
  assign pix_valid   = pix_q.valid;
  assign pix_data    = pix_q.data;
  assign frame_start = pix_q.fs;
  assign line_start  = pix_q.ls;
  assign frame_end   = pix_q.fe;
  assign frame_abort = abort_q;
  assign busy        = busy_q;
  assign err_flags   = err_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: random frames and
// FIFO traffic against a queue-based reference model.
module tb_conv_frame_ctrl;
  import conv_ctrl_pkg::*;

  localparam int         D  = 8;
  localparam logic [7:0] SC = 8'hA5;
  localparam logic [7:0] FB = 8'h00;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ssel_active = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       res_valid = 1'b0;
  logic [7:0] res_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       frame_start;
  logic       line_start;
  logic       frame_end;
  logic       frame_abort;
  logic [7:0] tx_byte;
  logic       busy;
  logic [3:0] err_flags;

  int n_cmp = 0;
  int n_bad = 0;
  int abort_cnt = 0;
  logic [10:0] got_q[$];
  logic [7:0]  mq[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  conv_frame_ctrl #(
    .FIFO_DEPTH (D),
    .START_CMD  (SC),
    .FILL_BYTE  (FB)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .ssel_active (ssel_active),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .frame_start (frame_start),
    .line_start  (line_start),
    .frame_end   (frame_end),
    .frame_abort (frame_abort),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .tx_req      (tx_req),
    .tx_byte     (tx_byte),
    .busy        (busy),
    .err_flags   (err_flags)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (pix_valid)
      got_q.push_back({frame_start, line_start, frame_end, pix_data});
    if (frame_abort)
      abort_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    int g;
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    g = $urandom_range(0, 2);
    repeat (g) tick();
  endtask

  // base >= 0 gives pixel data base+i, otherwise random data
  task automatic run_frame(input int w, input int h, input int n,
                           input int extra, input bit drop,
                           input int base);
    logic [10:0] exp_q[$];
    logic [7:0]  b;
    int tot;
    int a0;
    tot = w * h;
    got_q.delete();
    a0 = abort_cnt;
    ssel_active = 1'b1;
    tick();
    put(SC);
    put(8'(w));
    put(8'(h));
    chk("busy_hdr", busy, 1);
    for (int i = 0; i < n; i++) begin
      b = (base >= 0) ? 8'(base + i) : 8'($urandom);
      put(b);
      if (i < tot)
        exp_q.push_back({(i == 0), (i % w) == 0, (i == tot - 1), b});
    end
    for (int i = 0; i < extra; i++) put(8'($urandom));
    if (drop) begin
      rx_valid = 1'b1;
      rx_byte = 8'($urandom);
      ssel_active = 1'b0;
      tick();
      rx_valid = 1'b0;
    end else begin
      ssel_active = 1'b0;
    end
    repeat (3) tick();
    chk("pix_count", got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size()) chk("pixel", got_q[i], exp_q[i]);
    chk("abort_pulses", abort_cnt - a0, (n < tot) ? 1 : 0);
    chk("frame_flags", err_flags, (n < tot) ? 4'b0010 : 4'b0000);
    chk("busy_idle", busy, 0);
  endtask

  task automatic run_bad(input bit at_w);
    int a0;
    got_q.delete();
    ssel_active = 1'b1;
    tick();
    put(SC);
    if (!at_w) put(8'($urandom_range(1, 255)));
    put(8'h00);
    tick();
    chk("bad_flags", err_flags, 4'b0001);
    chk("bad_busy", busy, 1);
    put(8'h11);
    put(8'h22);
    a0 = abort_cnt;
    ssel_active = 1'b0;
    repeat (2) tick();
    chk("bad_nopix", got_q.size(), 0);
    chk("bad_silent", abort_cnt - a0, 0);
    chk("bad_sticky", err_flags, 4'b0001);
    ssel_active = 1'b1;
    tick();
    put(SC);
    chk("bad_cleared", err_flags, 4'b0000);
    ssel_active = 1'b0;
    repeat (3) tick();
  endtask

  task automatic fifo_cyc(input bit push, input bit pop,
                          input logic [7:0] d);
    bit pop_ok;
    bit push_ok;
    res_valid = push;
    res_data  = d;
    tx_req    = pop;
    tick();
    res_valid = 1'b0;
    tx_req    = 1'b0;
    pop_ok  = pop && (mq.size() > 0);
    push_ok = push && ((mq.size() < D) || pop_ok);
    if (push && !push_ok) m_ovf = 1'b1;
    if (pop && mq.size() == 0) m_udf = 1'b1;
    if (pop_ok) void'(mq.pop_front());
    if (push_ok) mq.push_back(d);
    @(negedge CLK);
    chk("tx_byte", tx_byte, (mq.size() > 0) ? mq[0] : FB);
    chk("ovf_flag", err_flags[ERR_OVF], m_ovf);
    chk("udf_flag", err_flags[ERR_UDF], m_udf);
    tick();
  endtask

  // start a frame then kill the header: flushes FIFO, clears flags
  task automatic fifo_reset();
    ssel_active = 1'b1;
    tick();
    put(SC);
    put(8'h00);
    ssel_active = 1'b0;
    repeat (2) tick();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    chk("clr_flags", err_flags, 4'b0001);
    chk("clr_tx", tx_byte, FB);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, h, tot, n, a0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_markers", {frame_start, line_start, frame_end}, 0);
    chk("rst_abort", frame_abort, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_tx", tx_byte, FB);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    tick();

    run_frame(3, 2, 6, 0, 1'b0, 'h10);
    run_frame(1, 1, 1, 2, 1'b0, 'h42);
    run_frame(4, 4, 5, 0, 1'b0, -1);
    run_frame(4, 4, 5, 0, 1'b1, -1);
    for (int k = 0; k < 10; k++) begin
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 4);
      tot = w * h;
      if ($urandom_range(0, 1) == 1)
        run_frame(w, h, tot, $urandom_range(0, 2),
                  1'($urandom_range(0, 1)), -1);
      else
        run_frame(w, h, $urandom_range(0, tot - 1), 0,
                  1'($urandom_range(0, 1)), -1);
    end

    run_bad(1'b1);
    run_bad(1'b0);

    fifo_reset();
    for (int i = 0; i <= D; i++) fifo_cyc(1'b1, 1'b0, 8'($urandom));
    chk("fill_ovf", err_flags[ERR_OVF], 1);
    for (int i = 0; i <= D; i++) fifo_cyc(1'b0, 1'b1, 8'h00);
    chk("drain_udf", err_flags[ERR_UDF], 1);

    fifo_reset();
    for (int i = 0; i < D; i++) fifo_cyc(1'b1, 1'b0, 8'($urandom));
    fifo_cyc(1'b1, 1'b1, 8'hC3);
    chk("full_pp_ovf", err_flags[ERR_OVF], 0);
    for (int i = 0; i < D; i++) fifo_cyc(1'b0, 1'b1, 8'h00);
    chk("full_pp_drained", tx_byte, FB);

    fifo_reset();
    fifo_cyc(1'b1, 1'b1, 8'h5A);
    chk("empty_pp_udf", err_flags[ERR_UDF], 1);
    chk("empty_pp_head", tx_byte, 8'h5A);
    fifo_cyc(1'b0, 1'b1, 8'h00);

    fifo_reset();
    for (int i = 0; i < 300; i++)
      fifo_cyc(1'($urandom_range(0, 99) < 55),
               1'($urandom_range(0, 99) < 45), 8'($urandom));

    got_q.delete();
    ssel_active = 1'b1;
    tick();
    put(SC);
    put(8'd4);
    put(8'd4);
    put(8'h31);
    rx_valid  = 1'b1;
    rx_byte   = 8'h77;
    res_valid = 1'b1;
    res_data  = 8'h3C;
    @(posedge CLK);
    #3;
    rx_valid  = 1'b0;
    res_valid = 1'b0;
    chk("pre_rst_pix", pix_valid, 1);
    chk("pre_rst_tx", tx_byte, 8'h3C);
    chk("pre_rst_busy", busy, 1);
    a0 = abort_cnt;
    RESET_N = 1'b0;
    #1;
    chk("arst_pix_valid", pix_valid, 0);
    chk("arst_pix_data", pix_data, 0);
    chk("arst_markers", {frame_start, line_start, frame_end}, 0);
    chk("arst_abort", frame_abort, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err_flags, 0);
    chk("arst_tx", tx_byte, FB);
    ssel_active = 1'b0;
    repeat (2) tick();
    RESET_N = 1'b1;
    repeat (3) tick();
    n = abort_cnt - a0;
    chk("arst_no_abort", n, 0);
    run_frame(2, 3, 6, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
